// File: rtl/imm_operand_pipe_if.sv
// Valid/ready stream carrying raw instruction fields in and formed immediates out.
// The master drives the upstream offer and the downstream ready; the slave is the pipe.
interface imm_operand_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_type;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_type, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_type, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_operand_pipe.sv
// Decode-stage immediate generator: forms the immediate at the input and carries it,
// with its tag and malformed flag, through a main register backed by one skid register.
module imm_operand_pipe #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    imm_operand_pipe_if.slave    bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam logic [2:0] T_ITYPE  = 3'd1;
    localparam logic [2:0] T_STYPE  = 3'd2;
    localparam logic [2:0] T_BTYPE  = 3'd3;
    localparam logic [2:0] T_UTYPE  = 3'd4;
    localparam logic [2:0] T_JTYPE  = 3'd5;
    localparam logic [2:0] T_ZTYPE  = 3'd6;
    localparam logic [2:0] T_SHTYPE = 3'd7;

    // Indexed by instruction bit number so the fields read like the ISA manual.
    logic [31:7] ins;
    logic        s;
    assign ins = bus.in_instr;
    assign s   = ins[31];

    logic [XLEN-1:0] new_imm;
    logic            new_err;

    always_comb begin
        new_imm = '0;
        new_err = 1'b0;
        case (bus.in_type)
            T_ITYPE:  new_imm = {{(XLEN-11){s}}, ins[30:20]};
            T_STYPE:  new_imm = {{(XLEN-11){s}}, ins[30:25], ins[11:7]};
            T_BTYPE:  new_imm = {{(XLEN-12){s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            T_UTYPE:  new_imm = {{(XLEN-31){s}}, ins[30:12], 12'b0};
            T_JTYPE:  new_imm = {{(XLEN-20){s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            T_ZTYPE:  new_imm = {{(XLEN-5){1'b0}}, ins[19:15]};
            T_SHTYPE: begin
                if (XLEN == 64) begin
                    new_imm = {{(XLEN-6){1'b0}}, ins[25:20]};
                end else begin
                    new_imm = {{(XLEN-5){1'b0}}, ins[24:20]};
                    new_err = ins[25];
                end
            end
            default:  new_imm = '0;
        endcase
    end

    logic             main_vld, skid_vld, rdy;
    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             main_err, skid_err;

    logic accept, xfer;
    logic main_vld_n, skid_vld_n;
    logic ld_main_new, ld_main_skid, ld_skid;

    assign accept = bus.in_valid & rdy;
    assign xfer   = main_vld & bus.out_ready;

    always_comb begin
        main_vld_n   = main_vld;
        skid_vld_n   = skid_vld;
        ld_main_new  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else begin
            if (xfer && skid_vld) begin
                ld_main_skid = 1'b1;
                skid_vld_n   = 1'b0;
            end else if (xfer) begin
                main_vld_n = 1'b0;
            end
            if (accept) begin
                if (!main_vld || (xfer && !skid_vld)) begin
                    ld_main_new = 1'b1;
                    main_vld_n  = 1'b1;
                end else begin
                    ld_skid    = 1'b1;
                    skid_vld_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy      <= 1'b1;
            main_imm <= '0;
            main_tag <= '0;
            main_err <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            main_vld <= main_vld_n;
            skid_vld <= skid_vld_n;
            // Registered ready: low exactly while the skid holds an entry.
            rdy      <= !skid_vld_n;
            if (ld_main_skid) begin
                main_imm <= skid_imm;
                main_tag <= skid_tag;
                main_err <= skid_err;
            end else if (ld_main_new) begin
                main_imm <= new_imm;
                main_tag <= bus.in_tag;
                main_err <= new_err;
            end
            if (ld_skid) begin
                skid_imm <= new_imm;
                skid_tag <= bus.in_tag;
                skid_err <= new_err;
            end
        end
    end

    // A transfer coinciding with flush has still been taken downstream, so it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (xfer && main_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = main_vld;
    assign bus.out_imm   = main_imm;
    assign bus.out_tag   = main_tag;
    assign bus.out_err   = main_err;
endmodule

// File: tb/tb_imm_operand_pipe.sv
// Drives an XLEN=32 (2-bit error counter) and an XLEN=64 pipe with the same stream
// and checks both against a queue model plus hand-computed literal values.
module tb_imm_operand_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  itype = '0;
    logic [31:0] tag = '0;
    logic [1:0]  err_cnt32;
    logic [7:0]  err_cnt64;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_operand_pipe_if #(.XLEN(32), .TAG_W(32)) if32 ();
    imm_operand_pipe_if #(.XLEN(64), .TAG_W(32)) if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = instr[31:7];
    assign if32.in_type   = itype;
    assign if32.in_tag    = tag;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = instr[31:7];
    assign if64.in_type   = itype;
    assign if64.in_tag    = tag;
    assign if64.out_ready = out_ready;

    imm_operand_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave), .err_cnt(err_cnt32)
    );
    imm_operand_pipe #(.XLEN(64), .TAG_W(32), .ERR_CNT_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave), .err_cnt(err_cnt64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] t, input int xlen);
        logic signed [63:0] v;
        case (t)
            3'd1:    v = 64'($signed(i[31:20]));
            3'd2:    v = 64'($signed({i[31:25], i[11:7]}));
            3'd3:    v = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd4:    v = 64'($signed({i[31:12], 12'h000}));
            3'd5:    v = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd6:    v = {59'd0, i[19:15]};
            3'd7:    v = (xlen == 64) ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            default: v = '0;
        endcase
        if (xlen == 32) v[63:32] = '0;
        return v;
    endfunction

    typedef struct packed {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        err32;
    } ent_t;

    ent_t q[$];
    int   m_cnt32 = 0;

    // Model: at most two entries held, FIFO order, flush empties, ready = room left.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_cnt32 = 0;
            end else begin
                bit   acc;
                bit   xf;
                ent_t e;
                acc = in_valid && (q.size() < 2);
                xf  = (q.size() > 0) && out_ready;
                e.imm32 = model_imm(instr, itype, 32);
                e.imm64 = model_imm(instr, itype, 64);
                e.tag   = tag;
                e.err32 = (itype == 3'd7) && instr[25];
                if (xf && q[0].err32 && m_cnt32 < 3) m_cnt32++;
                if (flush) begin
                    q.delete();
                end else begin
                    if (xf) void'(q.pop_front());
                    if (acc) q.push_back(e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("m_out_valid32", 64'(if32.out_valid), 64'(q.size() != 0));
                chk("m_out_valid64", 64'(if64.out_valid), 64'(q.size() != 0));
                chk("m_in_ready32", 64'(if32.in_ready), 64'(q.size() < 2));
                chk("m_in_ready64", 64'(if64.in_ready), 64'(q.size() < 2));
                chk("m_err_cnt32", 64'(err_cnt32), 64'(m_cnt32));
                chk("m_err_cnt64", 64'(err_cnt64), 64'd0);
                if (q.size() != 0) begin
                    chk("m_imm32", 64'(if32.out_imm), q[0].imm32);
                    chk("m_imm64", 64'(if64.out_imm), q[0].imm64);
                    chk("m_tag32", 64'(if32.out_tag), 64'(q[0].tag));
                    chk("m_tag64", 64'(if64.out_tag), 64'(q[0].tag));
                    chk("m_err32", 64'(if32.out_err), 64'(q[0].err32));
                    chk("m_err64", 64'(if64.out_err), 64'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] t, input logic [31:0] g);
        in_valid = v;
        instr    = i;
        itype    = t;
        tag      = g;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_out_valid"}, 64'(if32.out_valid | if64.out_valid), 64'd0);
        chk({pfx, "_in_ready"}, 64'(if32.in_ready & if64.in_ready), 64'd1);
        chk({pfx, "_imm32"}, 64'(if32.out_imm), 64'd0);
        chk({pfx, "_imm64"}, 64'(if64.out_imm), 64'd0);
        chk({pfx, "_tag"}, 64'(if32.out_tag | if64.out_tag), 64'd0);
        chk({pfx, "_err"}, 64'(if32.out_err | if64.out_err), 64'd0);
        chk({pfx, "_err_cnt"}, 64'(err_cnt32) | 64'(err_cnt64), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;

        drive(1'b1, 32'hFFF0_0093, 3'd1, 32'h100);
        step();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("itype_valid", 64'(if32.out_valid), 64'd1);
        chk("itype_imm32", 64'(if32.out_imm), 64'hFFFF_FFFF);
        chk("itype_imm64", 64'(if64.out_imm), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("itype_err", 64'(if32.out_err), 64'd0);
        chk("itype_tag", 64'(if32.out_tag), 64'h100);
        step();

        drive(1'b1, 32'hFE00_0EE3, 3'd3, 32'h101);
        step();
        chk("btype_imm32", 64'(if32.out_imm), 64'hFFFF_FFFC);
        drive(1'b1, 32'h0010_00EF, 3'd5, 32'h102);
        step();
        chk("jtype_imm32", 64'(if32.out_imm), 64'h0000_0800);
        chk("jtype_tag", 64'(if32.out_tag), 64'h102);
        drive(1'b1, 32'h000F_8073, 3'd6, 32'h103);
        step();
        chk("ztype_imm32", 64'(if32.out_imm), 64'h0000_001F);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        step();

        drive(1'b1, 32'h8000_00B7, 3'd4, 32'h104);
        step();
        chk("utype_imm64", 64'(if64.out_imm), 64'hFFFF_FFFF_8000_0000);
        chk("utype_imm32", 64'(if32.out_imm), 64'h8000_0000);
        drive(1'b1, 32'h03F0_0013, 3'd7, 32'h105);
        step();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("sh_imm64", 64'(if64.out_imm), 64'h3F);
        chk("sh_err64", 64'(if64.out_err), 64'd0);
        chk("sh_imm32", 64'(if32.out_imm), 64'h1F);
        chk("sh_err32", 64'(if32.out_err), 64'd1);
        chk("sh_cnt_before", 64'(err_cnt32), 64'd0);
        step();
        chk("sh_cnt_after", 64'(err_cnt32), 64'd1);

        drive(1'b1, 32'h03F0_0013, 3'd7, 32'h106);
        repeat (4) step();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        step();
        chk("sat_cnt32", 64'(err_cnt32), 64'd3);
        chk("sat_cnt64", 64'(err_cnt64), 64'd0);

        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 3'd1, 32'hA);
        step();
        chk("bp_a_valid", 64'(if32.out_valid), 64'd1);
        chk("bp_ready_after_a", 64'(if32.in_ready), 64'd1);
        drive(1'b1, 32'h0020_0093, 3'd1, 32'hB);
        step();
        chk("bp_ready_after_b", 64'(if32.in_ready), 64'd0);
        drive(1'b1, 32'h0030_0093, 3'd1, 32'hC);
        step();
        chk("bp_hold_ready", 64'(if32.in_ready), 64'd0);
        chk("bp_hold_tag", 64'(if32.out_tag), 64'hA);
        chk("bp_hold_imm", 64'(if32.out_imm), 64'h1);
        out_ready = 1'b1;
        step();
        chk("bp_tag_b", 64'(if32.out_tag), 64'hB);
        chk("bp_imm_b", 64'(if32.out_imm), 64'h2);
        chk("bp_ready_rise", 64'(if32.in_ready), 64'd1);
        step();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("bp_tag_c", 64'(if32.out_tag), 64'hC);
        chk("bp_valid_c", 64'(if32.out_valid), 64'd1);
        step();
        chk("bp_drained", 64'(if32.out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1'b1, 32'h0040_0093, 3'd1, 32'hE);
        step();
        drive(1'b1, 32'h0050_0093, 3'd1, 32'hF);
        step();
        drive(1'b1, 32'h0060_0093, 3'd1, 32'hD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("flush2_valid", 64'(if32.out_valid), 64'd0);
        chk("flush2_ready", 64'(if32.in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush2_no_d", 64'(if32.out_valid | if64.out_valid), 64'd0);
        end

        out_ready = 1'b0;
        drive(1'b1, 32'h0070_0093, 3'd1, 32'h1E);
        step();
        drive(1'b1, 32'h0080_0093, 3'd1, 32'h1D);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("flush1_valid", 64'(if32.out_valid), 64'd0);
        step();
        chk("flush1_no_d", 64'(if32.out_valid), 64'd0);

        drive(1'b1, 32'h0090_0093, 3'd1, 32'h77);
        step();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("rst_pre_valid", 64'(if32.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h00A0_0093, 3'd1, 32'h88);
        step();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("post_rst_tag", 64'(if32.out_tag), 64'h88);
        chk("post_rst_imm", 64'(if64.out_imm), 64'hA);
        step();
        chk("post_rst_empty", 64'(if32.out_valid), 64'd0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_operand_pipe.md
# imm_operand_pipe

Parametrised, registered immediate-operand generator for the decode stage of the pipelined RISC-V core. It extracts and sign- or zero-extends the immediate of one instruction per cycle, supports XLEN 32 or 64, and covers two formats beyond the base I/S/B/U/J set: CSR zimm and shift-amount. Instructions arrive and leave through valid/ready handshakes. A two-entry skid buffer keeps full throughput under back-pressure. A flush input serves branch redirects, and a saturating counter tracks malformed-immediate events.

## Interface
- XLEN, 32, output immediate width; legal values 32 and 64.
- TAG_W, 32, width of the opaque sideband tag (normally PC) carried alongside each instruction.
- ERR_CNT_W, 8, width of the saturating error counter.
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  block can accept; registered.
- in_instr  input  25  instruction bits [31:7]; LSB of the port is instruction bit 7.
- in_type  input  3  format: 0 NOIMM, 1 ITYPE, 2 STYPE, 3 BTYPE, 4 UTYPE, 5 JTYPE, 6 ZTYPE, 7 SHTYPE.
- in_tag  input  TAG_W  sideband; passed through unchanged.
- out_valid  output  1  out_imm, out_tag and out_err are valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the entry shown on the outputs.
- out_err  output  1  immediate field malformed for the configured XLEN.
- err_cnt  output  ERR_CNT_W  number of out_err transfers completed; saturates at all-ones.

## Operation
- Immediate formation, with S = instr[31] sign-extended to XLEN:
  - ITYPE: S, [30:20].
  - STYPE: S, [30:25], [11:7].
  - BTYPE: S, [7], [30:25], [11:8], 0.
  - UTYPE: S (XLEN=64 only), [31:12], 12'b0.
  - JTYPE: S, [19:12], [20], [30:21], 0.
  - ZTYPE: zero-extend [19:15].
  - SHTYPE: zero-extend [25:20] when XLEN=64, or [24:20] when XLEN=32.
  - NOIMM: all zeros.
- out_err is 1 only for SHTYPE with XLEN=32 and instr[25]=1; out_imm is still formed from [24:20].
- Immediate, err flag and tag are computed combinationally at the input and stored together in the entry.
- Storage is a main register (drives the outputs) plus one skid register.
  - Accept occurs when in_valid & in_ready.
  - Transfer occurs when out_valid & out_ready.
- Entry movement:
  - Accept while main is empty, or main is transferring with the skid empty: the entry loads into main.
  - Accept while main is full and not transferring: the entry loads into the skid.
  - Transfer with the skid full: the skid moves to main and the skid empties.
- in_ready is registered; its next value is !(skid full at the next edge).
- Ordering is strictly FIFO; entries are never dropped or duplicated except by flush.
- flush empties both entries and forces in_ready=1 at the next edge.
  - flush takes priority over a simultaneous accept (the input is discarded) and over a simultaneous transfer (the transfer still counts as completed downstream).
  - flush does not clear err_cnt.
- err_cnt increments on every transfer with out_err=1, and holds at its maximum value.

## Timing
- Reset (asynchronous assert, synchronous release effect): out_valid=0, in_ready=1, err_cnt=0, out_imm=0, out_tag=0, out_err=0, skid empty.
- Reset mid-operation discards all entries immediately.
- Latency: an input accepted at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 per cycle while out_ready=1.
- Back-pressure:
  - With out_ready=0, exactly two entries are accepted.
  - in_ready falls in the cycle after the second accept.
  - in_ready rises one cycle after the first transfer that empties the skid.
- Output data is stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Test plan
- XLEN=32: ITYPE, instr 0xFFF00093 -> out_imm 0xFFFFFFFF, out_err 0, one cycle after accept.
- XLEN=32: BTYPE 0xFE000EE3 -> 0xFFFFFFFC; JTYPE 0x001000EF -> 0x00000800; ZTYPE with [19:15]=5'b11111 -> 0x0000001F.
- XLEN=64: UTYPE 0x800000B7 -> 0xFFFFFFFF80000000; SHTYPE with [25:20]=6'h3F -> 0x3F with out_err 0.
  - Same SHTYPE at XLEN=32 -> out_imm 0x1F, out_err 1, err_cnt increments on transfer.
  - With ERR_CNT_W=2, four error transfers leave err_cnt at 3.
- Back-pressure: out_ready=0, push tags A, B, C -> A and B accepted, in_ready=0 the cycle after B, C held.
  - Raise out_ready -> A, B, C emerge in order with no gap.
- Flush: two entries buffered, flush asserted together with in_valid (tag D) -> next cycle out_valid=0, in_ready=1, D never appears.
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> outputs immediately take their reset values.
  - After release, the first accept is the next output.
